// File: rtl/nios2_system_v0_pulse_pio.sv
// Avalon-MM parallel output port with DATA/SET/CLEAR/PULSE write registers.
// Each output bit has its own down-counter that auto-clears the bit after a pulse.
module nios2_system_v0_pulse_pio #(
  parameter int unsigned             WIDTH        = 8,
  parameter logic [WIDTH-1:0]        RESET_VALUE  = '0,
  parameter int unsigned             PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned    CW   = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0]  LOAD = CW'(PULSE_CYCLES);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  logic             wr_en;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] busy;
  logic [CW-1:0]    cnt [WIDTH];

  // Bits above WIDTH-1 are intentionally ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en    = chipselect & ~write_n;
  assign out_port = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VALUE;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        // A register write on a bit wins over its counter expiring that cycle.
        if (wr_en && address == ADDR_DATA) begin
          out_q[i] <= writedata[i];
          cnt[i]   <= '0;
        end else if (wr_en && writedata[i]) begin
          case (address)
            ADDR_SET: begin
              out_q[i] <= 1'b1;
              cnt[i]   <= '0;
            end
            ADDR_CLEAR: begin
              out_q[i] <= 1'b0;
              cnt[i]   <= '0;
            end
            default: begin
              out_q[i] <= 1'b1;
              cnt[i]   <= LOAD;
            end
          endcase
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
          if (cnt[i] == CW'(1)) out_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(WIDTH); i++) busy[i] = (cnt[i] != '0);
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata[WIDTH-1:0] = out_q;
      ADDR_PULSE: readdata[WIDTH-1:0] = busy;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2_system_v0_pulse_pio.sv
// Directed bench for nios2_system_v0_pulse_pio with WIDTH=8, RESET_VALUE=8'h5A, PULSE_CYCLES=4.
module tb_nios2_system_v0_pulse_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_cmp = 0;
  int n_err = 0;

  nios2_system_v0_pulse_pio #(
    .WIDTH(8),
    .RESET_VALUE(8'h5A),
    .PULSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // Reset with a simultaneous write: reset must win.
    reset = 1'b1; address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFF;
    tick();
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    check("reset_out", {24'h0, out_port}, 32'h5A);
    reset = 1'b0;
    tick();
    check("post_reset_out", {24'h0, out_port}, 32'h5A);
    rd_check("reset_rd_data", 2'd0, 32'h0000005A);
    rd_check("reset_rd_busy", 2'd3, 32'h0);

    // Qualified writes only.
    address = 2'd0; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b1;
    tick();
    check("wn_high_noeffect", {24'h0, out_port}, 32'h5A);
    chipselect = 1'b0; write_n = 1'b0;
    tick();
    check("cs_low_noeffect", {24'h0, out_port}, 32'h5A);
    write_n = 1'b1;

    // DATA / SET / CLEAR.
    do_write(2'd0, 32'hFFFF_FF0F);
    check("data_0F", {24'h0, out_port}, 32'h0F);
    do_write(2'd1, 32'h30);
    check("set_3F", {24'h0, out_port}, 32'h3F);
    do_write(2'd2, 32'h05);
    check("clear_3A", {24'h0, out_port}, 32'h3A);
    rd_check("rd_addr1_zero", 2'd1, 32'h0);
    rd_check("rd_addr2_zero", 2'd2, 32'h0);
    chipselect = 1'b1;
    rd_check("rd_cs_indep", 2'd0, 32'h3A);
    chipselect = 1'b0;

    // Basic pulse: high exactly 4 cycles.
    do_write(2'd0, 32'h0);
    do_write(2'd3, 32'h81);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("pulse81_out_c%0d", k), {24'h0, out_port}, 32'h81);
      rd_check($sformatf("pulse81_busy_c%0d", k), 2'd3, 32'h81);
      tick();
    end
    check("pulse81_end_out", {24'h0, out_port}, 32'h0);
    rd_check("pulse81_end_busy", 2'd3, 32'h0);

    // Retrigger two cycles in: 6 cycles high total.
    do_write(2'd3, 32'h01);
    check("retrig_c1", {24'h0, out_port}, 32'h01);
    tick();
    check("retrig_c2", {24'h0, out_port}, 32'h01);
    do_write(2'd3, 32'h01);
    check("retrig_c3", {24'h0, out_port}, 32'h01);
    for (int k = 4; k <= 6; k++) begin
      tick();
      check($sformatf("retrig_c%0d", k), {24'h0, out_port}, 32'h01);
    end
    tick();
    check("retrig_end", {24'h0, out_port}, 32'h0);

    // CLEAR cancels a pulse.
    do_write(2'd3, 32'h02);
    check("pulse02_c1", {24'h0, out_port}, 32'h02);
    do_write(2'd2, 32'h02);
    check("clear_cancel_out", {24'h0, out_port}, 32'h0);
    rd_check("clear_cancel_busy", 2'd3, 32'h0);

    // DATA write on the expiry edge wins.
    do_write(2'd3, 32'h02);
    tick();
    tick();
    tick();
    check("expiry_pre", {24'h0, out_port}, 32'h02);
    do_write(2'd0, 32'h02);
    check("expiry_data_out", {24'h0, out_port}, 32'h02);
    rd_check("expiry_data_busy", 2'd3, 32'h0);
    tick();
    tick();
    check("expiry_data_hold", {24'h0, out_port}, 32'h02);

    // SET cancels a pulse; bit stays high.
    do_write(2'd3, 32'h04);
    do_write(2'd1, 32'h04);
    rd_check("set_cancel_busy", 2'd3, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("set_cancel_hold", {24'h0, out_port}, 32'h06);

    // Reset mid-pulse.
    do_write(2'd0, 32'h0);
    do_write(2'd3, 32'hFF);
    check("pulseFF_c1", {24'h0, out_port}, 32'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midpulse_reset_out", {24'h0, out_port}, 32'h5A);
    rd_check("midpulse_reset_busy", 2'd3, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("midpulse_reset_hold", {24'h0, out_port}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_system_v0_pulse_pio.md
NIOS2_SYSTEM_V0_PULSE_PIO -- requirements
Module: nios2_system_v0_pulse_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the output port width in bits (legal 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the out_port value after reset (WIDTH bits).
REQ-003 The block SHALL have parameter PULSE_CYCLES, default 16, meaning the high time of a pulsed bit in clk cycles (legal 1..65535).
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port address, input, 2: Avalon-MM word address.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe.
REQ-009 Port writedata, input, 32: write data; bits above WIDTH-1 ignored.
REQ-010 Port readdata, output, 32: read data, combinational from address, zero wait states.
REQ-011 Port out_port, output, WIDTH: registered parallel output.

Function
REQ-012 A write SHALL occur on a cycle with chipselect=1 and write_n=0; there is no other handshake, no waitrequest, and no read side effects.
REQ-013 Address 0 (DATA) write SHALL load out_port <= writedata[WIDTH-1:0] and cancel all active pulses.
REQ-014 Address 1 (SET) write SHALL set every out_port bit whose writedata bit is 1, cancelling any pulse on those bits; other bits unchanged.
REQ-015 Address 2 (CLEAR) write SHALL clear every out_port bit whose writedata bit is 1, cancelling any pulse on those bits; other bits unchanged.
REQ-016 Address 3 (PULSE) write SHALL, for each writedata bit that is 1, set that out_port bit and load its per-bit counter with PULSE_CYCLES; other bits unchanged.
REQ-017 A pulsed bit SHALL read 1 at out_port for exactly PULSE_CYCLES cycles, beginning the cycle after the write edge, then return to 0 automatically.
REQ-018 Each bit SHALL have an independent down-counter, width ceil(log2(PULSE_CYCLES+1)); the bit is busy while its counter is nonzero.
REQ-019 A PULSE write to an already-busy bit SHALL reload its counter to PULSE_CYCLES (retrigger); the bit stays 1 with no glitch.
REQ-020 If a register write targets a bit in the same cycle its counter expires, the write SHALL take precedence.
REQ-021 Read address 0 SHALL return out_port zero-extended to 32 bits; address 3 SHALL return the busy mask zero-extended; addresses 1 and 2 SHALL return 0.
REQ-022 readdata SHALL depend only on address and current state, irrespective of chipselect.
REQ-023 Writes with write_n=1 or chipselect=0 SHALL have no effect.

Reset
REQ-024 With reset=1 at a clk rising edge, out_port SHALL become RESET_VALUE and all counters 0 (busy mask 0), overriding any simultaneous write.
REQ-025 Reset asserted mid-pulse SHALL terminate the pulse; out_port takes RESET_VALUE, not 0.
REQ-026 Outputs SHALL not change asynchronously on reset; before the first reset edge their values are undefined.

Verification (WIDTH=8, RESET_VALUE=8'h5A, PULSE_CYCLES=4)
REQ-027 Reset then read addr 0 -> readdata=32'h0000005A; read addr 3 -> 0.
REQ-028 Write DATA 32'hFFFF_FF0F, then SET 8'h30, then CLEAR 8'h05 -> out_port 8'h0F, 8'h3F, 8'h3A in successive cycles.
REQ-029 From out_port=8'h00, write PULSE 8'h81 -> out_port 8'h81 for exactly 4 cycles, 8'h00 on cycle 5; busy read = 8'h81 during the pulse, 0 after.
REQ-030 PULSE 8'h01, then PULSE 8'h01 again 2 cycles later -> bit 0 high 6 cycles total, no dropout.
REQ-031 PULSE 8'h02, then CLEAR 8'h02 one cycle later -> bit 1 low from the next cycle, busy 0; DATA write 8'h02 on the expiry cycle -> bit 1 stays 1.
REQ-032 PULSE 8'hFF from 8'h00, reset asserted 2 cycles in -> out_port 8'h5A, busy 0, no later auto-clear.
